// File: rtl/uart_transceiver.sv
// 8N1 UART transceiver: 16x oversampled receiver with two-flop input
// synchronizer, and a transmitter timing each bit as exactly 16*DIV clocks.
module uart_transceiver #(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned BAUD     = 9600,
  parameter int unsigned DIV      = CLK_FREQ / (BAUD * 16)
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Rx,
  output logic       Tx,
  input  logic [7:0] TxData,
  input  logic       TxStart,
  output logic [7:0] RxData,
  output logic       RxRdy,
  output logic       TxRdy,
  output logic       TxBusy,
  output logic       FrameErr
);

  localparam int unsigned TW = $clog2(DIV);
  localparam int unsigned BW = $clog2(16 * DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(16 * DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // ---------------- receiver ----------------
  logic          rx1, rxs;
  state_t        rx_state, rx_state_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [3:0]    s, s_n;
  logic [2:0]    ridx, ridx_n;
  logic [7:0]    rsr, rsr_n, rxdata_n;
  logic          rxrdy_n, ferr_n, tick;

  // Two-flop synchronizer for the asynchronous Rx pin; idles high.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      rx1 <= 1'b1;
      rxs <= 1'b1;
    end else begin
      rx1 <= Rx;
      rxs <= rx1;
    end
  end

  // Receiver state and datapath registers.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      rx_state <= IDLE;
      tcnt     <= '0;
      s        <= '0;
      ridx     <= '0;
      rsr      <= '0;
      RxData   <= '0;
      RxRdy    <= 1'b0;
      FrameErr <= 1'b0;
    end else begin
      rx_state <= rx_state_n;
      tcnt     <= tcnt_n;
      s        <= s_n;
      ridx     <= ridx_n;
      rsr      <= rsr_n;
      RxData   <= rxdata_n;
      RxRdy    <= rxrdy_n;
      FrameErr <= ferr_n;
    end
  end

  // Receiver next-state: tick divider, mid-bit sampling, stop-bit validation.
  always_comb begin
    rx_state_n = rx_state;
    s_n        = s;
    ridx_n     = ridx;
    rsr_n      = rsr;
    rxdata_n   = RxData;
    rxrdy_n    = 1'b0;
    ferr_n     = 1'b0;
    tick       = (tcnt == TICK_LAST);
    if (rx_state == IDLE) tcnt_n = '0;
    else if (tick)        tcnt_n = '0;
    else                  tcnt_n = tcnt + TW'(1);
    unique case (rx_state)
      IDLE: begin
        if (!rxs) begin
          rx_state_n = START;
          s_n        = '0;
        end
      end
      START: begin
        if (tick) begin
          if (s == 4'd7) begin
            if (rxs) rx_state_n = IDLE;
            else begin
              rx_state_n = DATA;
              s_n        = '0;
              ridx_n     = '0;
            end
          end else s_n = s + 4'd1;
        end
      end
      DATA: begin
        if (tick) begin
          s_n = s + 4'd1;
          if (s == 4'd15) begin
            rsr_n = {rxs, rsr[7:1]};
            if (ridx == 3'd7) rx_state_n = STOP;
            else              ridx_n = ridx + 3'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          s_n = s + 4'd1;
          if (s == 4'd15) begin
            if (rxs) begin
              rxdata_n = rsr;
              rxrdy_n  = 1'b1;
            end else ferr_n = 1'b1;
            rx_state_n = IDLE;
          end
        end
      end
      default: rx_state_n = IDLE;
    endcase
  end

  // ---------------- transmitter ----------------
  state_t        tx_state, tx_state_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic [2:0]    tidx, tidx_n;
  logic [7:0]    tsr, tsr_n;
  logic          tx_n, txbusy_n, txrdy_n;

  // Transmitter state and registered pin/flag outputs.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      tx_state <= IDLE;
      bcnt     <= '0;
      tidx     <= '0;
      tsr      <= '0;
      Tx       <= 1'b1;
      TxBusy   <= 1'b0;
      TxRdy    <= 1'b0;
    end else begin
      tx_state <= tx_state_n;
      bcnt     <= bcnt_n;
      tidx     <= tidx_n;
      tsr      <= tsr_n;
      Tx       <= tx_n;
      TxBusy   <= txbusy_n;
      TxRdy    <= txrdy_n;
    end
  end

  // Transmitter next-state; outputs are decoded from the next state so the
  // registered Tx/TxBusy/TxRdy line up with the state they describe.
  always_comb begin
    tx_state_n = tx_state;
    bcnt_n     = bcnt;
    tidx_n     = tidx;
    tsr_n      = tsr;
    unique case (tx_state)
      IDLE: begin
        if (TxStart) begin
          tsr_n      = TxData;
          bcnt_n     = '0;
          tx_state_n = START;
        end
      end
      START: begin
        if (bcnt == BIT_LAST) begin
          bcnt_n     = '0;
          tidx_n     = '0;
          tx_state_n = DATA;
        end else bcnt_n = bcnt + BW'(1);
      end
      DATA: begin
        if (bcnt == BIT_LAST) begin
          bcnt_n = '0;
          tsr_n  = {1'b0, tsr[7:1]};
          if (tidx == 3'd7) tx_state_n = STOP;
          else              tidx_n = tidx + 3'd1;
        end else bcnt_n = bcnt + BW'(1);
      end
      STOP: begin
        if (bcnt == BIT_LAST) tx_state_n = IDLE;
        else                  bcnt_n = bcnt + BW'(1);
      end
      default: tx_state_n = IDLE;
    endcase
    tx_n     = (tx_state_n == START) ? 1'b0 :
               (tx_state_n == DATA)  ? tsr_n[0] : 1'b1;
    txbusy_n = (tx_state_n != IDLE);
    txrdy_n  = (tx_state_n == STOP) && (bcnt_n == BIT_LAST);
  end

endmodule

// File: tb/tb_uart_transceiver.sv
// Scoreboard bench for uart_transceiver: stimulus pushes expected events,
// independent monitors decode the Tx line and the Rx event pulses.
module tb_uart_transceiver;
  localparam int unsigned CLK_FREQ = 1600000;
  localparam int unsigned BAUD     = 10000;
  localparam int BITC = 160;

  logic       Clk = 1'b0, Rst = 1'b0, Rx = 1'b1, TxStart = 1'b0;
  logic [7:0] TxData = '0;
  logic       Tx, RxRdy, TxRdy, TxBusy, FrameErr;
  logic [7:0] RxData;

  uart_transceiver #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .Clk(Clk), .Rst(Rst), .Rx(Rx), .Tx(Tx), .TxData(TxData), .TxStart(TxStart),
    .RxData(RxData), .RxRdy(RxRdy), .TxRdy(TxRdy), .TxBusy(TxBusy), .FrameErr(FrameErr)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct { logic err; logic [7:0] data; int c; } rx_exp_t;
  typedef struct { logic [7:0] data; int start; } tx_exp_t;
  rx_exp_t rxq[$];
  tx_exp_t txq[$];

  int   errors = 0, checks = 0;
  bit   mon_en = 0, tx_in_frame = 0;
  int   tx_free = 0, tx_issued = 0, rx_issued = 0, txrdy_cnt = 0;
  logic [7:0] last_good = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  initial begin
    #(90000 * 10);
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

  // Reference: 8N1 frame on the pin, LSB first, one bit per BITC clocks.
  task automatic send_rx(input logic [7:0] b, input logic stop);
    rx_exp_t e;
    @(negedge Clk);
    Rx = 1'b0;
    e.err = ~stop;
    if (stop) last_good = b;
    e.data = last_good;
    e.c = cyc;
    rxq.push_back(e);
    rx_issued++;
    repeat (BITC) @(negedge Clk);
    for (int i = 0; i < 8; i++) begin
      Rx = b[i];
      repeat (BITC) @(negedge Clk);
    end
    Rx = stop;
    repeat (BITC) @(negedge Clk);
    Rx = 1'b1;
    repeat (40) @(negedge Clk);
  endtask

  // Reference: a request is accepted once the previous frame (start + 1600
  // clocks) is over; the line goes low in the cycle after acceptance.
  task automatic send_tx(input logic [7:0] b);
    tx_exp_t e;
    @(negedge Clk);
    while (cyc < tx_free) @(negedge Clk);
    TxData = b;
    TxStart = 1'b1;
    e.data = b;
    e.start = cyc + 1;
    txq.push_back(e);
    tx_issued++;
    tx_free = e.start + 10 * BITC;
    @(negedge Clk);
    TxStart = 1'b0;
    TxData = 8'($urandom);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((rxq.size() != 0 || txq.size() != 0 || tx_in_frame) && n < 5000) begin
      @(negedge Clk);
      n++;
    end
    chk("drain_timeout", 32'(n < 5000), 32'd1);
    repeat (20) @(negedge Clk);
  endtask

  // Tx line monitor: decodes each frame by sampling mid-bit.
  initial forever begin
    @(negedge Clk);
    if (mon_en && Tx === 1'b0) begin
      int s0;
      logic [7:0] got;
      tx_exp_t e;
      s0 = cyc;
      tx_in_frame = 1;
      got = '0;
      for (int k = 0; k < 10; k++) begin
        while (cyc != s0 + BITC / 2 + BITC * k) @(negedge Clk);
        if (k == 0)      chk("tx_start_bit", 32'(Tx), 32'd0);
        else if (k == 9) chk("tx_stop_bit", 32'(Tx), 32'd1);
        else             got[k-1] = Tx;
        if (k == 0 || k == 9) chk($sformatf("tx_busy_bit%0d", k), 32'(TxBusy), 32'd1);
      end
      while (cyc != s0 + 10 * BITC - 2) @(negedge Clk);
      chk("txrdy_early", 32'(TxRdy), 32'd0);
      @(negedge Clk);
      chk("txrdy_last_stop_cycle", 32'(TxRdy), 32'd1);
      chk("txbusy_last_stop_cycle", 32'(TxBusy), 32'd1);
      @(negedge Clk);
      chk("txbusy_after_frame", 32'(TxBusy), 32'd0);
      chk("txrdy_single_cycle", 32'(TxRdy), 32'd0);
      if (txq.size() == 0) begin
        chk("tx_unexpected_frame", 32'(got), 32'hFFFF_FFFF);
      end else begin
        e = txq.pop_front();
        chk("tx_data", 32'(got), 32'(e.data));
        chk("tx_start_cycle", 32'(s0), 32'(e.start));
      end
      tx_in_frame = 0;
    end
  end

  // Rx event monitor: each RxRdy/FrameErr pulse retires one expected event.
  initial forever begin
    @(negedge Clk);
    if (mon_en && TxRdy) txrdy_cnt++;
    if (mon_en && (RxRdy || FrameErr)) begin
      rx_exp_t e;
      if (rxq.size() == 0) begin
        chk("rx_unexpected_event", {30'd0, RxRdy, FrameErr}, 32'd0);
      end else begin
        e = rxq.pop_front();
        chk("rx_event_kind", {30'd0, RxRdy, FrameErr}, e.err ? 32'd1 : 32'd2);
        chk("rx_data", 32'(RxData), 32'(e.data));
        chk("rx_event_latency", 32'((cyc >= e.c + 1515) && (cyc <= e.c + 1530)), 32'd1);
      end
    end
  end

  initial begin
    int pulses, txlow;
    // Reset held with a toggling Rx line.
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      Rx = ~Rx;
    end
    chk("reset_tx", 32'(Tx), 32'd1);
    chk("reset_rxdata", 32'(RxData), 32'd0);
    chk("reset_flags", {28'd0, RxRdy, TxRdy, TxBusy, FrameErr}, 32'd0);
    Rx = 1'b1;
    @(negedge Clk);
    Rst = 1'b1;
    pulses = 0;
    txlow = 0;
    repeat (2000) begin
      @(negedge Clk);
      if (RxRdy || TxRdy || FrameErr || TxBusy) pulses++;
      if (Tx !== 1'b1) txlow++;
    end
    chk("post_reset_pulses", 32'(pulses), 32'd0);
    chk("post_reset_tx_idle", 32'(txlow), 32'd0);
    mon_en = 1;

    // Single byte transmit.
    send_tx(8'hA5);
    wait_drain();

    // TxStart held across two frames; TxData changes mid-frame.
    begin
      tx_exp_t e;
      int c;
      @(negedge Clk);
      TxData = 8'h3C;
      TxStart = 1'b1;
      c = cyc;
      e.data = 8'h3C; e.start = c + 1;
      txq.push_back(e);
      repeat (800) @(negedge Clk);
      TxData = 8'hC3;
      while (cyc < c + 1 + 10 * BITC) @(negedge Clk);
      e.data = 8'hC3; e.start = c + 2 + 10 * BITC;
      txq.push_back(e);
      tx_issued += 2;
      repeat (400) @(negedge Clk);
      TxData = 8'h99;
      repeat (400) @(negedge Clk);
      TxStart = 1'b0;
      tx_free = e.start + 10 * BITC;
    end
    wait_drain();

    // Good receive.
    send_rx(8'h5A, 1'b1);
    wait_drain();

    // Short glitch on Rx, then a valid byte.
    @(negedge Clk);
    Rx = 1'b0;
    repeat (40) @(negedge Clk);
    Rx = 1'b1;
    repeat (300) @(negedge Clk);
    send_rx(8'hFF, 1'b1);
    wait_drain();

    // Framing error while a transmit is in flight.
    fork
      send_rx(8'h81, 1'b0);
      send_tx(8'h00);
    join
    wait_drain();

    // Randomized overlapping traffic.
    for (int i = 0; i < 5; i++) begin
      logic [7:0] rb, tb;
      logic st;
      rb = 8'($urandom);
      tb = 8'($urandom);
      st = ($urandom_range(0, 3) != 0);
      fork
        send_rx(rb, st);
        send_tx(tb);
      join
    end
    wait_drain();
    chk("txrdy_pulse_count", 32'(txrdy_cnt), 32'(tx_issued));
    chk("rx_events_retired", 32'(rxq.size()), 32'd0);

    // Asynchronous reset in the middle of both frames.
    mon_en = 0;
    @(negedge Clk);
    TxData = 8'h00;
    TxStart = 1'b1;
    Rx = 1'b0;
    @(negedge Clk);
    TxStart = 1'b0;
    repeat (700) @(negedge Clk);
    chk("abort_pre_tx_low", 32'(Tx), 32'd0);
    chk("abort_pre_busy", 32'(TxBusy), 32'd1);
    #2 Rst = 1'b0;
    #1;
    chk("abort_tx_high_async", 32'(Tx), 32'd1);
    chk("abort_busy_clear_async", 32'(TxBusy), 32'd0);
    chk("abort_rxdata_clear", 32'(RxData), 32'd0);
    repeat (5) @(negedge Clk);
    Rx = 1'b1;
    Rst = 1'b1;
    pulses = 0;
    txlow = 0;
    repeat (2000) begin
      @(negedge Clk);
      if (RxRdy || TxRdy || FrameErr || TxBusy) pulses++;
      if (Tx !== 1'b1) txlow++;
    end
    chk("post_abort_pulses", 32'(pulses), 32'd0);
    chk("post_abort_tx_idle", 32'(txlow), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_transceiver.md
Name: uart_transceiver

Overview:
- Memory-mapped serial peripheral behind the CPU's data-RAM/peripheral decode.
- Converts the Rx pin into bytes and bytes into the Tx pin, 8N1 framing.
- Produces the RxRdy/TxRdy event pulses that feed the interrupt request and Cause register.
- The RAM/peripheral decoder drives TxData/TxStart and reads RxData and the status flags.

Parameters:
- CLK_FREQ, 50000000: system clock frequency in Hz.
- BAUD, 9600: serial bit rate.
- DIV, CLK_FREQ/(BAUD*16): clocks per 16x oversample tick; integer truncation; must be >= 2.

Ports:
- Clk  input  1  system clock; all state changes on the rising edge.
- Rst  input  1  asynchronous, active-low reset.
- Rx  input  1  serial input pin; asynchronous to Clk.
- Tx  output  1  serial output pin; idles high.
- TxData  input  8  byte to transmit; sampled only on an accepted TxStart.
- TxStart  input  1  transmit request; accepted only when TxBusy=0.
- RxData  output  8  last correctly framed received byte.
- RxRdy  output  1  one-cycle pulse when RxData is updated.
- TxRdy  output  1  one-cycle pulse when a transmission completes.
- TxBusy  output  1  high while a byte is being transmitted.
- FrameErr  output  1  one-cycle pulse when a stop bit is sampled low.

Behaviour:
- Reset (Rst=0, asynchronous):
  - Outputs: Tx=1, RxData=0, RxRdy=0, TxRdy=0, TxBusy=0, FrameErr=0.
  - Both FSMs go to IDLE; all counters clear.
  - Reset mid-frame aborts the frame with no pulses. Tx returns high immediately, not at a clock edge.
- Rx synchronizer: two flip-flops. rxs is the second-stage output. All receive decisions use rxs only (2-cycle input latency).
- Rx tick generator: counter 0..DIV-1; tick asserts when the count is DIV-1. It is held at 0 while the Rx FSM is IDLE.
- Rx FSM, states IDLE, START, DATA, STOP; s counts ticks 0..15 within a bit.
  - IDLE: rxs=0 -> START with s=0.
  - START: on the tick where s=7, rxs=1 means a false start -> IDLE. Otherwise s resets and the FSM -> DATA with bit index 0.
  - DATA: on each tick where s=15, sample rxs into the shift register LSB first. After bit index 7 -> STOP.
  - STOP: on the tick where s=15 (mid stop bit), behaviour depends on rxs:
    - rxs=1: RxData <= shift register and RxRdy pulses for 1 cycle.
    - rxs=0: FrameErr pulses for 1 cycle and RxData is unchanged.
    - In both cases the FSM -> IDLE in the same cycle.
  - The next start edge is detectable from the following cycle.
- Tx FSM, states IDLE, START, DATA, STOP. It uses its own bit counter 0..16*DIV-1, so every bit lasts exactly 16*DIV clocks.
  - Accept (IDLE and TxStart=1), cycle N:
    - TxData is latched.
    - From cycle N+1: TxBusy=1, Tx=0 (start bit), bit counter=0.
  - DATA: bits 0..7 are driven LSB first, each for 16*DIV clocks.
  - STOP: Tx=1 for 16*DIV clocks. In the last stop-bit cycle TxRdy=1 for 1 cycle. TxBusy falls and the FSM -> IDLE in the following cycle.
  - A TxStart during TxBusy=1, or in the TxRdy cycle, is ignored: no queuing, and TxData is not re-sampled.
  - A TxStart in the first cycle with TxBusy=0 is accepted, allowing back-to-back frames with no idle gap.
- Rx and Tx are fully independent. Simultaneous RxRdy, TxRdy and FrameErr in the same cycle are legal, each a separate pulse.
- An overrun (new byte before software reads) silently overwrites RxData.
- Event pulses are never stretched. The consumer latches them (Cause register).

Test Plan:
All scenarios use CLK_FREQ=1600000 and BAUD=10000, giving DIV=10 and a bit period of 160 clocks.
- Reset: hold Rst=0 with Rx toggling -> Tx=1, all flags 0, RxData=0. Release Rst -> no pulses for 2000 cycles while Rx=1.
- TX single byte: pulse TxStart with TxData=8'hA5 at cycle N -> Tx observed as 0,1,0,1,0,0,1,0,1,1, each bit for 160 clocks starting N+1. TxRdy high exactly at cycle N+1600. TxBusy high on N+1..N+1600.
- TX busy/back-to-back: TxStart held high with 8'h3C, then 8'hC3 loaded mid-frame -> the first frame is 8'h3C. The second frame, carrying whichever TxData is present at the first TxBusy=0 cycle, starts with no gap. No extra frames are sent.
- RX good byte: drive 8'h5A as 8N1 at 10000 baud -> RxData=8'h5A and one RxRdy pulse about 1520+2 cycles after the start edge. FrameErr stays 0.
- RX glitch/false start: drive Rx low for 40 clocks, then high -> no RxRdy, no FrameErr, FSM back in IDLE. A valid 8'hFF received afterwards gives RxData=8'hFF.
- RX framing error and concurrency: send 8'h81 with stop bit=0 while transmitting 8'h00 -> FrameErr pulses, RxData holds its previous value. The TX frame completes with TxRdy unaffected.
